// File: rtl/id_decode_stage.sv
// id_decode_stage: IF->EX decode stage with a 2-entry skid buffer.
// Define ID_ILLEGAL_TRAP_EN to pass illegal words to EX flagged by ex_illegal.
package id_decode_pkg;
  localparam logic [2:0] INST_R    = 3'd0;
  localparam logic [2:0] INST_I    = 3'd1;
  localparam logic [2:0] INST_S    = 3'd2;
  localparam logic [2:0] INST_B    = 3'd3;
  localparam logic [2:0] INST_U    = 3'd4;
  localparam logic [2:0] INST_J    = 3'd5;
  localparam logic [2:0] ILLEGAL_T = 3'b111;
endpackage

module id_sext
  import id_decode_pkg::*;
(
  input  logic [24:0] imm_in_i,
  input  logic [2:0]  type_i,
  input  logic        shift_i,
  output logic [31:0] imm_o
);
  // imm_in_i[k] is inst[k+7]
  always_comb begin
    imm_o = '0;
    unique case (type_i)
      INST_I:
        if (shift_i) imm_o = {27'd0, imm_in_i[17:13]};
        else imm_o = {{20{imm_in_i[24]}}, imm_in_i[24:13]};
      INST_S:
        imm_o = {{20{imm_in_i[24]}}, imm_in_i[24:18],
                 imm_in_i[4:0]};
      INST_B:
        imm_o = {{19{imm_in_i[24]}}, imm_in_i[24], imm_in_i[0],
                 imm_in_i[23:18], imm_in_i[4:1], 1'b0};
      INST_U:
        imm_o = {{12{imm_in_i[24]}}, imm_in_i[24:5]};
      INST_J:
        imm_o = {{12{imm_in_i[24]}}, imm_in_i[24], imm_in_i[12:5],
                 imm_in_i[13], imm_in_i[23:14]};
      default: imm_o = '0;
    endcase
  end
endmodule

module id_decode_stage
  import id_decode_pkg::*;
#(
  parameter int unsigned PC_W     = 32,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_inst,
  input  logic [PC_W-1:0] if_pc,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [PC_W-1:0] ex_pc,
  output logic [31:0]     ex_inst,
  output logic [2:0]      ex_inst_type,
  output logic [31:0]     ex_imm,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd
`ifdef ID_ILLEGAL_TRAP_EN
  ,
  output logic            ex_illegal
`endif
);
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     inst;
    logic [2:0]      typ;
    logic [31:0]     imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } ent_t;

  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

  localparam ent_t RST_ENT = '{pc: '0, inst: NOP_INST,
                               typ: INST_I, imm: '0,
                               rs1: '0, rs2: '0, rd: '0};

  state_t      state_q, state_d;
  logic        rdy_q;
  ent_t        head_q, skid_q, dec;
  logic [2:0]  dec_type;
  logic        dec_shift;
  logic [31:0] sext_imm;
  logic        push, pop;

  assign push = if_valid & rdy_q;
  assign pop  = ex_valid & ex_ready;

  always_comb begin
    dec_type  = ILLEGAL_T;
    dec_shift = 1'b0;
    unique case (if_inst[6:0])
      7'b0110011: dec_type = INST_R;
      7'b0010011: begin
        dec_type  = INST_I;
        dec_shift = (if_inst[14:12] == 3'b001) |
                    (if_inst[14:12] == 3'b101);
      end
      7'b0000011, 7'b1100111,
      7'b1110011, 7'b0001111: dec_type = INST_I;
      7'b0100011: dec_type = INST_S;
      7'b1100011: dec_type = INST_B;
      7'b0110111, 7'b0010111: dec_type = INST_U;
      7'b1101111: dec_type = INST_J;
      default: dec_type = ILLEGAL_T;
    endcase
  end

  id_sext u_sext (
    .imm_in_i (if_inst[31:7]),
    .type_i   (dec_type),
    .shift_i  (dec_shift),
    .imm_o    (sext_imm)
  );

  always_comb begin
    dec.pc   = if_pc;
    dec.inst = if_inst;
    dec.typ  = dec_type;
    dec.imm  = sext_imm;
    dec.rs1  = if_inst[19:15];
    dec.rs2  = if_inst[24:20];
    dec.rd   = if_inst[11:7];
`ifndef ID_ILLEGAL_TRAP_EN
    // Unknown opcodes become a harmless NOP
    if (dec_type == ILLEGAL_T) begin
      dec.inst = NOP_INST;
      dec.typ  = INST_I;
      dec.imm  = '0;
      dec.rs1  = NOP_INST[19:15];
      dec.rs2  = NOP_INST[24:20];
      dec.rd   = NOP_INST[11:7];
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (push) state_d = FULL;
      FULL: begin
        if (push && !pop) state_d = SKID;
        else if (pop && !push) state_d = EMPTY;
      end
      SKID: if (pop) state_d = FULL;
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      rdy_q   <= 1'b0;
      head_q  <= RST_ENT;
      skid_q  <= RST_ENT;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != SKID);
      if (!flush) begin
        if (push && (state_q == EMPTY || pop)) head_q <= dec;
        else if (pop && state_q == SKID) head_q <= skid_q;
        if (push && !pop && state_q == FULL) skid_q <= dec;
      end
    end
  end

  assign if_ready     = rdy_q;
  assign ex_valid     = (state_q != EMPTY);
  assign ex_pc        = head_q.pc;
  assign ex_inst      = head_q.inst;
  assign ex_inst_type = head_q.typ;
  assign ex_imm       = head_q.imm;
  assign ex_rs1       = head_q.rs1;
  assign ex_rs2       = head_q.rs2;
  assign ex_rd        = head_q.rd;
`ifdef ID_ILLEGAL_TRAP_EN
  assign ex_illegal   = (head_q.typ == ILLEGAL_T) |
                        (head_q.inst[1:0] != 2'b11);
`endif
endmodule

// File: tb/tb_id_decode_stage.sv
// Testbench for id_decode_stage: directed decode/flow cases plus
// randomized traffic against a queue-based reference model.
module tb_id_decode_stage;
  localparam logic [2:0]  T_R = 3'd0, T_I = 3'd1, T_S = 3'd2;
  localparam logic [2:0]  T_B = 3'd3, T_U = 3'd4, T_J = 3'd5;
  localparam logic [2:0]  T_ILL = 3'd7;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        if_valid = 1'b0;
  logic        ex_ready = 1'b0;
  logic [31:0] if_inst = '0;
  logic [31:0] if_pc = '0;
  logic        if_ready, ex_valid;
  logic [31:0] ex_pc, ex_inst, ex_imm;
  logic [2:0]  ex_inst_type;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
`ifdef ID_ILLEGAL_TRAP_EN
  logic        ex_illegal;
`endif

  always #5 clk = ~clk;

  id_decode_stage dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .if_valid     (if_valid),
    .if_ready     (if_ready),
    .if_inst      (if_inst),
    .if_pc        (if_pc),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_pc        (ex_pc),
    .ex_inst      (ex_inst),
    .ex_inst_type (ex_inst_type),
    .ex_imm       (ex_imm),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .ex_rd        (ex_rd)
`ifdef ID_ILLEGAL_TRAP_EN
    ,
    .ex_illegal   (ex_illegal)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [2:0]  typ;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
`ifdef ID_ILLEGAL_TRAP_EN
    logic        ill;
`endif
  } e_t;

  e_t q[$];
  bit m_rdy = 1'b0;
  int checks = 0;
  int failures = 0;

  function automatic e_t ref_dec(input logic [31:0] inst,
                                 input logic [31:0] pc);
    e_t e;
    logic [11:0] s;
    logic [12:0] b;
    logic [19:0] j;
    s = {inst[31:25], inst[11:7]};
    b = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    j = {inst[31], inst[19:12], inst[20], inst[30:21]};
    e.pc = pc;
    e.inst = inst;
    e.rs1 = inst[19:15];
    e.rs2 = inst[24:20];
    e.rd = inst[11:7];
    e.imm = '0;
    e.typ = T_ILL;
`ifdef ID_ILLEGAL_TRAP_EN
    e.ill = 1'b0;
`endif
    case (inst[6:0])
      7'h33: e.typ = T_R;
      7'h13: begin
        e.typ = T_I;
        if (inst[14:12] == 3'd1 || inst[14:12] == 3'd5)
          e.imm = {27'd0, inst[24:20]};
        else
          e.imm = $signed(inst) >>> 20;
      end
      7'h03, 7'h67, 7'h73, 7'h0F: begin
        e.typ = T_I;
        e.imm = $signed(inst) >>> 20;
      end
      7'h23: begin e.typ = T_S; e.imm = {{20{s[11]}}, s}; end
      7'h63: begin e.typ = T_B; e.imm = {{19{b[12]}}, b}; end
      7'h37, 7'h17: begin
        e.typ = T_U;
        e.imm = $signed(inst) >>> 12;
      end
      7'h6F: begin e.typ = T_J; e.imm = {{12{j[19]}}, j}; end
      default: e.typ = T_ILL;
    endcase
    if (e.typ == T_ILL) begin
`ifdef ID_ILLEGAL_TRAP_EN
      e.ill = 1'b1;
`else
      e.inst = NOP;
      e.typ = T_I;
      e.rs1 = '0;
      e.rs2 = '0;
      e.rd = '0;
`endif
    end
`ifdef ID_ILLEGAL_TRAP_EN
    if (inst[1:0] != 2'b11) e.ill = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [31:0] rnd_inst();
    logic [6:0]  ops [11];
    logic [31:0] r;
    int unsigned k;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F,
            7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    r = $urandom;
    k = $urandom_range(0, 12);
    if (k < 11) return {r[31:7], ops[k]};
    return r;
  endfunction

  // Advance the model with the inputs the DUT sees at this edge
  task automatic step();
    bit push, pop;
    if (rst) begin
      q.delete();
      m_rdy = 1'b0;
    end else if (flush) begin
      q.delete();
      m_rdy = 1'b1;
    end else begin
      push = if_valid && m_rdy;
      pop = (q.size() > 0) && ex_ready;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(ref_dec(if_inst, if_pc));
      m_rdy = (q.size() < 2);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_valid = 1'b1;
    if_inst = 32'hFFF00093;
    step();
    step();
    checks++;
    if (ex_valid !== 1'b0 || if_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs valid=%b ready=%b exp 0 0",
               ex_valid, if_ready);
    end
    checks++;
    if (ex_pc !== 32'd0 || ex_inst !== NOP) begin
      failures++;
      $display("FAIL reset_pc_inst pc=%h inst=%h exp 0 %h",
               ex_pc, ex_inst, NOP);
    end
    checks++;
    if (ex_inst_type !== T_I || ex_imm !== 32'd0) begin
      failures++;
      $display("FAIL reset_type_imm type=%0d imm=%h exp %0d 0",
               ex_inst_type, ex_imm, T_I);
    end
    checks++;
    if ({ex_rs1, ex_rs2, ex_rd} !== 15'd0) begin
      failures++;
      $display("FAIL reset_regs rs1=%0d rs2=%0d rd=%0d exp 0",
               ex_rs1, ex_rs2, ex_rd);
    end
`ifdef ID_ILLEGAL_TRAP_EN
    checks++;
    if (ex_illegal !== 1'b0) begin
      failures++;
      $display("FAIL reset_illegal got=%b exp 0", ex_illegal);
    end
`endif
    rst = 1'b0;
    if_valid = 1'b0;
    step();
    checks++;
    if (if_ready !== 1'b1 || ex_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release ready=%b valid=%b exp 1 0",
               if_ready, ex_valid);
    end
  endtask

  task automatic test_decode();
    logic [31:0] ins [7];
    logic [31:0] imms [7];
    logic [31:0] einst [7];
    logic [2:0]  typs [7];
    logic [4:0]  rds [7];
    ins  = '{32'hFFF00093, 32'h40515193, 32'hFE20AE23,
             32'hFE000EE3, 32'h800000EF, 32'h123452B7,
             32'h0000007F};
    imms = '{32'hFFFFFFFF, 32'h00000005, 32'hFFFFFFFC,
             32'hFFFFFFFC, 32'hFFF80000, 32'h00012345,
             32'h00000000};
    rds  = '{5'd1, 5'd3, 5'd28, 5'd29, 5'd1, 5'd5, 5'd0};
    einst = ins;
`ifdef ID_ILLEGAL_TRAP_EN
    typs = '{T_I, T_I, T_S, T_B, T_J, T_U, T_ILL};
`else
    typs = '{T_I, T_I, T_S, T_B, T_J, T_U, T_I};
    einst[6] = NOP;
`endif
    ex_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if_valid = 1'b1;
      if_inst = ins[i];
      if_pc = 32'h100 + 32'(4 * i);
      step();
      if_valid = 1'b0;
      checks++;
      if (ex_valid !== 1'b1 || ex_pc !== 32'h100 + 32'(4 * i)) begin
        failures++;
        $display("FAIL dec%0d_valid valid=%b pc=%h exp 1 %h", i,
                 ex_valid, ex_pc, 32'h100 + 32'(4 * i));
      end
      checks++;
      if (ex_inst_type !== typs[i] || ex_imm !== imms[i]) begin
        failures++;
        $display("FAIL dec%0d_type_imm type=%0d imm=%h exp %0d %h",
                 i, ex_inst_type, ex_imm, typs[i], imms[i]);
      end
      checks++;
      if (ex_inst !== einst[i] || ex_rd !== rds[i]) begin
        failures++;
        $display("FAIL dec%0d_inst_rd inst=%h rd=%0d exp %h %0d",
                 i, ex_inst, ex_rd, einst[i], rds[i]);
      end
`ifdef ID_ILLEGAL_TRAP_EN
      checks++;
      if (ex_illegal !== (i == 6)) begin
        failures++;
        $display("FAIL dec%0d_illegal got=%b exp %b", i,
                 ex_illegal, (i == 6));
      end
`endif
    end
    step();
    checks++;
    if (ex_valid !== 1'b0) begin
      failures++;
      $display("FAIL dec_drain valid=%b exp 0", ex_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, c;
    logic [31:0] got[$];
    a = 32'h00500113;
    b = 32'h00A00193;
    c = 32'h00F00213;
    ex_ready = 1'b0;
    if_valid = 1'b1;
    if_inst = a;
    if_pc = 32'h200;
    step();
    checks++;
    if (ex_valid !== 1'b1 || ex_inst !== a || if_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_first valid=%b inst=%h ready=%b exp 1 %h 1",
               ex_valid, ex_inst, if_ready, a);
    end
    if_inst = b;
    if_pc = 32'h204;
    step();
    checks++;
    if (if_ready !== 1'b0 || ex_inst !== a) begin
      failures++;
      $display("FAIL bp_second ready=%b inst=%h exp 0 %h",
               if_ready, ex_inst, a);
    end
    if_inst = c;
    if_pc = 32'h208;
    step();
    checks++;
    if (if_ready !== 1'b0 || ex_inst !== a || ex_pc !== 32'h200) begin
      failures++;
      $display("FAIL bp_hold ready=%b inst=%h pc=%h exp 0 %h 200",
               if_ready, ex_inst, ex_pc, a);
    end
    if_valid = 1'b0;
    ex_ready = 1'b1;
    for (int i = 0; i < 6 && ex_valid; i++) begin
      got.push_back(ex_inst);
      step();
    end
    checks++;
    if (got.size() != 2) begin
      failures++;
      $display("FAIL bp_count got=%0d exp 2", got.size());
    end else begin
      checks++;
      if (got[0] !== a || got[1] !== b) begin
        failures++;
        $display("FAIL bp_order got=%h,%h exp %h,%h",
                 got[0], got[1], a, b);
      end
    end
    checks++;
    if (if_ready !== 1'b1 || ex_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain ready=%b valid=%b exp 1 0",
               if_ready, ex_valid);
    end
  endtask

  task automatic test_flush();
    logic [31:0] d, e;
    bit seen;
    d = 32'h7FF00313;
    e = 32'h00300393;
    ex_ready = 1'b0;
    if_valid = 1'b1;
    if_inst = 32'h00100293;
    step();
    if_inst = 32'h00200293;
    step();
    flush = 1'b1;
    if_inst = d;
    step();
    flush = 1'b0;
    if_valid = 1'b0;
    checks++;
    if (ex_valid !== 1'b0 || if_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_skid valid=%b ready=%b exp 0 1",
               ex_valid, if_ready);
    end
    if_valid = 1'b1;
    if_inst = 32'h00400413;
    step();
    flush = 1'b1;
    if_inst = d;
    step();
    flush = 1'b0;
    if_valid = 1'b0;
    ex_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (ex_valid) seen = 1'b1;
      step();
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL flush_full_push valid seen=1 exp 0");
    end
    if_valid = 1'b1;
    if_inst = e;
    step();
    if_valid = 1'b0;
    checks++;
    if (ex_valid !== 1'b1 || ex_inst !== e) begin
      failures++;
      $display("FAIL flush_next valid=%b inst=%h exp 1 %h",
               ex_valid, ex_inst, e);
    end
    step();
  endtask

  task automatic test_reset_full();
    ex_ready = 1'b0;
    if_valid = 1'b1;
    if_inst = 32'h800000EF;
    if_pc = 32'h300;
    step();
    if_valid = 1'b0;
    rst = 1'b1;
    step();
    checks++;
    if (ex_valid !== 1'b0 || if_ready !== 1'b0 ||
        ex_pc !== 32'd0 || ex_inst !== NOP) begin
      failures++;
      $display("FAIL rstfull_a valid=%b ready=%b pc=%h inst=%h",
               ex_valid, if_ready, ex_pc, ex_inst);
    end
    checks++;
    if (ex_inst_type !== T_I || ex_imm !== 32'd0 || ex_rd !== 5'd0) begin
      failures++;
      $display("FAIL rstfull_b type=%0d imm=%h rd=%0d exp 1 0 0",
               ex_inst_type, ex_imm, ex_rd);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_random();
    e_t h;
    for (int n = 0; n < 600; n++) begin
      if_valid = ($urandom_range(0, 3) != 0);
      ex_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 24) == 0);
      if_inst = rnd_inst();
      if_pc = $urandom & 32'hFFFF_FFFC;
      step();
      checks++;
      if (ex_valid !== (q.size() > 0) || if_ready !== m_rdy) begin
        failures++;
        $display("FAIL rnd%0d_hs valid=%b ready=%b exp %b %b", n,
                 ex_valid, if_ready, (q.size() > 0), m_rdy);
      end
      if (q.size() > 0) begin
        h = q[0];
        checks++;
        if (ex_pc !== h.pc || ex_inst !== h.inst ||
            ex_inst_type !== h.typ ||
            (h.typ != T_R && ex_imm !== h.imm) ||
            ex_rs1 !== h.rs1 || ex_rs2 !== h.rs2 || ex_rd !== h.rd
`ifdef ID_ILLEGAL_TRAP_EN
            || ex_illegal !== h.ill
`endif
           ) begin
          failures++;
          $display("FAIL rnd%0d_head pc=%h inst=%h type=%0d imm=%h exp %h %h %0d %h",
                   n, ex_pc, ex_inst, ex_inst_type, ex_imm,
                   h.pc, h.inst, h.typ, h.imm);
        end
      end
    end
    flush = 1'b0;
    if_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_reset_full();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
